indication_pipe_arbiter: RTL and testbench



---
 rtl/indication_pipe_pkg.sv | 19 +
 rtl/indication_rr_picker.sv | 29 ++
 rtl/indication_pipe_arbiter.sv | 101 ++++++++++
 tb/tb_indication_pipe_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/indication_pipe_pkg.sv
// Shared constants for the indication pipe arbiter: message geometry and debug field offsets.
package indication_pipe_pkg;

  localparam int unsigned MSG_WIDTH       = 96;
  localparam int unsigned DEFAULT_NUM_REQ = 4;

  // Field layout of an opaque message; the arbiter never looks inside.
  localparam int unsigned TAG_LSB  = 64;
  localparam int unsigned TAG_MSB  = 95;
  localparam int unsigned METH_LSB = 32;
  localparam int unsigned METH_MSB = 63;
  localparam int unsigned V_LSB    = 0;
  localparam int unsigned V_MSB    = 31;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/indication_rr_picker.sv
// Combinational round-robin picker: first valid index at or after rr_ptr, modulo NUM_REQ.
module indication_rr_picker
  import indication_pipe_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  localparam int unsigned PTR_W  = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               found,
  output logic [PTR_W-1:0]   winner
);

  int unsigned idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && valid[PTR_W'(idx)]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/indication_pipe_arbiter.sv
// Shares one indication pipe between NUM_REQ sources via one-entry holding buffers,
// a round-robin picker and a single registered output stage.
module indication_pipe_arbiter
  import indication_pipe_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEFAULT_NUM_REQ,
  parameter int unsigned MSG_WIDTH = indication_pipe_pkg::MSG_WIDTH
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_REQ-1:0]           req_enq__ENA,
  input  logic [NUM_REQ*MSG_WIDTH-1:0] req_enq_v,
  output logic [NUM_REQ-1:0]           req_enq__RDY,
  output logic                         pipe_enq__ENA,
  output logic [MSG_WIDTH-1:0]         pipe_enq_v,
  input  logic                         pipe_enq__RDY,
  output logic [31:0]                  sent_count,
  output logic                         busy
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0]   hold_valid;
  logic [MSG_WIDTH-1:0] hold_data [NUM_REQ];
  logic                 out_valid;
  logic [MSG_WIDTH-1:0] out_data;
  logic [PTR_W-1:0]     rr_ptr;
  logic [31:0]          sent_cnt;

  logic [NUM_REQ-1:0]   enq_fire;
  logic                 deq;
  logic                 can_load;
  logic                 found;
  logic [PTR_W-1:0]     winner;
  logic                 load;
  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     rr_next;

  indication_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid  (hold_valid),
    .rr_ptr (rr_ptr),
    .found  (found),
    .winner (winner)
  );

  assign req_enq__RDY  = ~hold_valid;
  assign enq_fire      = req_enq__ENA & req_enq__RDY;
  assign pipe_enq_v    = out_data;
  assign pipe_enq__ENA = out_valid & pipe_enq__RDY;
  assign deq           = pipe_enq__ENA;
  assign sent_count    = sent_cnt;
  assign busy          = (|hold_valid) | out_valid;

  // Dequeue and reload in the same cycle keeps the output stage streaming without bubbles.
  always_comb begin
    can_load = !out_valid || deq;
    load     = can_load && found;
    grant    = '0;
    rr_next  = rr_ptr;
    if (load) begin
      grant   = NUM_REQ'(1) << winner;
      rr_next = (32'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hold_valid <= '0;
      out_valid  <= 1'b0;
      rr_ptr     <= '0;
      sent_cnt   <= '0;
    end else begin
      // A granted source cannot also enqueue this cycle: its RDY was low.
      hold_valid <= (hold_valid | enq_fire) & ~grant;
      rr_ptr     <= rr_next;
      if (load) begin
        out_valid <= 1'b1;
      end else if (deq) begin
        out_valid <= 1'b0;
      end
      if (deq) begin
        sent_cnt <= sent_cnt + 32'd1;
      end
    end
  end

  // Payload registers carry no reset; their contents are qualified by the valid bits.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (enq_fire[i]) begin
        hold_data[i] <= req_enq_v[i*MSG_WIDTH +: MSG_WIDTH];
      end
    end
    if (load) begin
      out_data <= hold_data[winner];
    end
  end

endmodule

// File: tb/tb_indication_pipe_arbiter.sv
// Directed and randomized checks of indication_pipe_arbiter against per-source FIFO expectations.
module tb_indication_pipe_arbiter;

  localparam int N = 4;
  localparam int W = 96;

  logic               CLK = 1'b0;
  logic               nRST;
  logic [N-1:0]       req_enq__ENA;
  logic [N*W-1:0]     req_enq_v;
  logic [N-1:0]       req_enq__RDY;
  logic               pipe_enq__ENA;
  logic [W-1:0]       pipe_enq_v;
  logic               pipe_enq__RDY;
  logic [31:0]        sent_count;
  logic               busy;

  int checks = 0;
  int errors = 0;

  indication_pipe_arbiter #(
    .NUM_REQ   (N),
    .MSG_WIDTH (W)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .req_enq__ENA  (req_enq__ENA),
    .req_enq_v     (req_enq_v),
    .req_enq__RDY  (req_enq__RDY),
    .pipe_enq__ENA (pipe_enq__ENA),
    .pipe_enq_v    (pipe_enq_v),
    .pipe_enq__RDY (pipe_enq__RDY),
    .sent_count    (sent_count),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input int src, input int seq, input logic [31:0] v);
    return {32'(src), 32'(seq), v};
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] d);
    req_enq_v[i*W +: W] = d;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    req_enq__ENA = '0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  logic [W-1:0] exp_seq [5];
  logic [W-1:0] q [N][$];
  int seqn [N];
  int delivered;
  int src;
  int budget;
  int leftover;

  initial begin
    nRST = 1'b0;
    req_enq__ENA = '0;
    req_enq_v = '0;
    pipe_enq__RDY = 1'b1;

    // Reset with all enables asserted.
    req_enq__ENA = '1;
    tick();
    tick();
    nRST = 1'b1;
    req_enq__ENA = '0;
    #1;
    check("reset_rdy", W'(req_enq__RDY), W'(4'hF));
    check("reset_pipe_ena", W'(pipe_enq__ENA), W'(0));
    check("reset_sent", W'(sent_count), W'(0));
    check("reset_busy", W'(busy), W'(0));

    // Single source latency.
    req_enq__ENA = 4'b0100;
    set_req(2, 96'h00000001_0000000A_000000FF);
    tick();
    req_enq__ENA = '0;
    #1;
    check("lat_no_ena_yet", W'(pipe_enq__ENA), W'(0));
    check("lat_rdy2_low", W'(req_enq__RDY[2]), W'(0));
    tick();
    check("lat_ena", W'(pipe_enq__ENA), W'(1));
    check("lat_value", pipe_enq_v, 96'h00000001_0000000A_000000FF);
    check("lat_rdy2_back", W'(req_enq__RDY[2]), W'(1));
    tick();
    check("lat_sent", W'(sent_count), W'(1));
    check("lat_idle", W'(busy), W'(0));

    // Round-robin burst from all sources.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, mk(i, 0, 32'h10 + 32'(i)));
    req_enq__ENA = '1;
    tick();
    req_enq__ENA = '0;
    tick();
    for (int k = 0; k < N; k++) begin
      check($sformatf("rr_ena_%0d", k), W'(pipe_enq__ENA), W'(1));
      check($sformatf("rr_val_%0d", k), W'(pipe_enq_v[31:0]), W'(32'h10 + 32'(k)));
      tick();
    end
    check("rr_done", W'(pipe_enq__ENA), W'(0));
    check("rr_ptr_zero", W'(dut.rr_ptr), W'(0));
    check("rr_sent", W'(sent_count), W'(4));

    // Pointer at 2 after serving source 1; sources 0 and 3 then contend.
    do_reset();
    set_req(1, mk(1, 0, 32'hA1));
    req_enq__ENA = 4'b0010;
    tick();
    req_enq__ENA = '0;
    tick();
    tick();
    set_req(0, mk(0, 0, 32'hB0));
    set_req(3, mk(3, 0, 32'hB3));
    req_enq__ENA = 4'b1001;
    tick();
    req_enq__ENA = '0;
    tick();
    check("fair_first", pipe_enq_v, mk(3, 0, 32'hB3));
    tick();
    check("fair_second", pipe_enq_v, mk(0, 0, 32'hB0));
    check("fair_second_ena", W'(pipe_enq__ENA), W'(1));
    tick();
    check("fair_idle", W'(busy), W'(0));

    // Downstream stall: one message in the output stage, four held.
    do_reset();
    pipe_enq__RDY = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, mk(i, 0, 32'hC0 + 32'(i)));
    req_enq__ENA = '1;
    tick();
    req_enq__ENA = '0;
    tick();
    check("stall_rdy_src0", W'(req_enq__RDY), W'(4'b0001));
    set_req(0, mk(0, 1, 32'hD0));
    req_enq__ENA = 4'b0001;
    tick();
    req_enq__ENA = '0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("stall_val_%0d", k), pipe_enq_v, mk(0, 0, 32'hC0));
      check($sformatf("stall_ena_%0d", k), W'(pipe_enq__ENA), W'(0));
      check($sformatf("stall_rdy_%0d", k), W'(req_enq__RDY), W'(0));
      tick();
    end
    exp_seq[0] = mk(0, 0, 32'hC0);
    exp_seq[1] = mk(1, 0, 32'hC1);
    exp_seq[2] = mk(2, 0, 32'hC2);
    exp_seq[3] = mk(3, 0, 32'hC3);
    exp_seq[4] = mk(0, 1, 32'hD0);
    pipe_enq__RDY = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain_ena_%0d", k), W'(pipe_enq__ENA), W'(1));
      check($sformatf("drain_val_%0d", k), pipe_enq_v, exp_seq[k]);
      tick();
    end
    check("drain_done", W'(pipe_enq__ENA), W'(0));
    check("drain_sent", W'(sent_count), W'(5));

    // Reset while messages are pending.
    pipe_enq__RDY = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, mk(i, 7, 32'hE0));
    req_enq__ENA = 4'b0111;
    tick();
    req_enq__ENA = '0;
    tick();
    check("midrst_busy", W'(busy), W'(1));
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    pipe_enq__RDY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("midrst_quiet_%0d", k), W'(pipe_enq__ENA), W'(0));
      tick();
    end
    check("midrst_sent", W'(sent_count), W'(0));

    // Counter wrap.
    force dut.sent_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.sent_cnt;
    #1;
    check("wrap_pre", W'(sent_count), W'(32'hFFFF_FFFF));
    set_req(0, mk(0, 9, 32'hF0));
    req_enq__ENA = 4'b0001;
    tick();
    req_enq__ENA = '0;
    tick();
    check("wrap_ena", W'(pipe_enq__ENA), W'(1));
    tick();
    check("wrap_zero", W'(sent_count), W'(0));

    // Randomized traffic against per-source FIFO scoreboards.
    do_reset();
    delivered = 0;
    for (int i = 0; i < N; i++) seqn[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        req_enq__ENA[i] = 1'b0;
        if (req_enq__RDY[i] && ($urandom % 2 == 0)) begin
          req_enq__ENA[i] = 1'b1;
          set_req(i, mk(i, seqn[i], $urandom));
          q[i].push_back(mk(i, seqn[i], req_enq_v[i*W +: 32]));
          seqn[i]++;
        end
      end
      pipe_enq__RDY = ($urandom % 4) != 0;
      #1;
      if (pipe_enq__ENA) begin
        src = int'(pipe_enq_v[95:64]);
        if (src >= 0 && src < N && q[src].size() > 0) begin
          check($sformatf("rand_order_c%0d", cyc), pipe_enq_v, q[src].pop_front());
        end else begin
          check($sformatf("rand_unexpected_c%0d", cyc), pipe_enq_v, '0 - 1);
        end
        delivered++;
      end
      tick();
    end
    req_enq__ENA = '0;
    pipe_enq__RDY = 1'b1;
    budget = 0;
    #1;
    while (busy && budget < 50) begin
      if (pipe_enq__ENA) begin
        src = int'(pipe_enq_v[95:64]);
        if (src >= 0 && src < N && q[src].size() > 0) begin
          check("drain_order", pipe_enq_v, q[src].pop_front());
        end else begin
          check("drain_unexpected", pipe_enq_v, '0 - 1);
        end
        delivered++;
      end
      tick();
      budget++;
    end
    check("rand_drained", W'(busy), W'(0));
    leftover = 0;
    for (int i = 0; i < N; i++) leftover += q[i].size();
    check("rand_no_loss", W'(leftover), W'(0));
    check("rand_sent_count", W'(sent_count), W'(delivered));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
